conjugate_complex_vxc_add_8_delay: RTL and testbench

CONJUGATE_COMPLEX_VXC_ADD_8_DELAY -- requirements
Module: conjugate_complex_vXc_add_8_delay

---
 rtl/conjugate_complex_vxc_add_8_delay.sv | 153 +++++++++++++++
 tb/tb_conjugate_complex_vxc_add_8_delay.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/conjugate_complex_vxc_add_8_delay.sv
// Conjugate complex multiply-accumulate across NI parallel lanes.
// Each lane computes R[k] = B[k] +/- C*conj(A[k]) in signed Q(W/2-FRAC).FRAC
// fixed point. The datapath is a 3-stage pipeline with no stall: operands,
// then the four products, then the result. finish_out marks the first edge
// at which the pipeline holds data sampled after reset.
module conjugate_complex_vxc_add_8_delay #(
  parameter int NI   = 8,
  parameter int W    = 64,
  parameter int FRAC = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NI*W-1:0] first_row_input,
  input  logic [W-1:0]    constant,
  input  logic [NI*W-1:0] second_row_input,
  input  logic            op,
  output logic [NI*W-1:0] vXc_add_8_output,
  output logic            finish_out
);

  localparam int H = W / 2;

  // Full-precision signed product, arithmetic shift right by FRAC, truncated to H bits.
  function automatic logic [H-1:0] fx_mul(input logic [H-1:0] x, input logic [H-1:0] y);
    logic signed [2*H-1:0] p;
    p = $signed({{H{x[H-1]}}, x}) * $signed({{H{y[H-1]}}, y});
    p = p >>> FRAC;
    return p[H-1:0];
  endfunction

  // Stage 1: operand registers
  logic [NI*W-1:0] a_r;
  logic [NI*W-1:0] b_r;
  logic [W-1:0]    c_r;
  logic            op_r;

  // Stage 2: products plus B and op travelling alongside
  logic [NI*H-1:0] rr_r;  // Cr*Ar
  logic [NI*H-1:0] ii_r;  // Ci*Ai
  logic [NI*H-1:0] ir_r;  // Ci*Ar
  logic [NI*H-1:0] ri_r;  // Cr*Ai
  logic [NI*W-1:0] b2_r;
  logic            op2_r;

  // Stage 3: result
  logic [NI*W-1:0] out_r;

  // Fill tracking
  logic [1:0] fill_r;
  logic       finish_r;

  logic [NI*H-1:0] rr_s;
  logic [NI*H-1:0] ii_s;
  logic [NI*H-1:0] ir_s;
  logic [NI*H-1:0] ri_s;
  logic [NI*W-1:0] r_s;

  logic [H-1:0] cr_s;
  logic [H-1:0] ci_s;

  assign cr_s = c_r[W-1:H];
  assign ci_s = c_r[H-1:0];

  for (genvar k = 0; k < NI; k++) begin : g_lane
    logic [H-1:0] ar_s;
    logic [H-1:0] ai_s;
    logic [H-1:0] br_s;
    logic [H-1:0] bi_s;
    logic [H-1:0] pr_s;
    logic [H-1:0] pi_s;

    assign ar_s = a_r[W*k+H +: H];
    assign ai_s = a_r[W*k +: H];

    assign rr_s[H*k +: H] = fx_mul(cr_s, ar_s);
    assign ii_s[H*k +: H] = fx_mul(ci_s, ai_s);
    assign ir_s[H*k +: H] = fx_mul(ci_s, ar_s);
    assign ri_s[H*k +: H] = fx_mul(cr_s, ai_s);

    // P = C*conj(A): Pr = CrAr + CiAi, Pi = CiAr - CrAi, all modulo 2^H
    assign pr_s = rr_r[H*k +: H] + ii_r[H*k +: H];
    assign pi_s = ir_r[H*k +: H] - ri_r[H*k +: H];

    assign br_s = b2_r[W*k+H +: H];
    assign bi_s = b2_r[W*k +: H];

    assign r_s[W*k+H +: H] = op2_r ? (br_s - pr_s) : (br_s + pr_s);
    assign r_s[W*k +: H]   = op2_r ? (bi_s - pi_s) : (bi_s + pi_s);
  end

  // Stage 1: capture all operands and op every cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_r  <= '0;
      b_r  <= '0;
      c_r  <= '0;
      op_r <= 1'b0;
    end else begin
      a_r  <= first_row_input;
      b_r  <= second_row_input;
      c_r  <= constant;
      op_r <= op;
    end
  end

  // Stage 2: register the four products, carry B and op forward
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_r  <= '0;
      ii_r  <= '0;
      ir_r  <= '0;
      ri_r  <= '0;
      b2_r  <= '0;
      op2_r <= 1'b0;
    end else begin
      rr_r  <= rr_s;
      ii_r  <= ii_s;
      ir_r  <= ir_s;
      ri_r  <= ri_s;
      b2_r  <= b_r;
      op2_r <= op_r;
    end
  end

  // Stage 3: register the lane results
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_r <= '0;
    end else begin
      out_r <= r_s;
    end
  end

  // Count the first three edges after reset, then hold finish high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_r   <= 2'd0;
      finish_r <= 1'b0;
    end else if (!finish_r) begin
      if (fill_r == 2'd2) begin
        finish_r <= 1'b1;
      end else begin
        fill_r <= fill_r + 2'd1;
      end
    end else begin
      finish_r <= 1'b1;
    end
  end

  assign vXc_add_8_output = out_r;
  assign finish_out       = finish_r;

endmodule

// File: tb/tb_conjugate_complex_vxc_add_8_delay.sv
// Directed testbench for conjugate_complex_vxc_add_8_delay with hand-computed
// Q16.16 vectors, checking reset behaviour, latency, finish_out and wrap-around.
module tb_conjugate_complex_vxc_add_8_delay;

  localparam int NI = 8;
  localparam int W  = 64;
  localparam int NV = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NI*W-1:0] a;
  logic [NI*W-1:0] b;
  logic [W-1:0]    c;
  logic            op;
  logic [NI*W-1:0] r;
  logic            fin;

  logic [NI*W-1:0] va [NV];
  logic [NI*W-1:0] vb [NV];
  logic [W-1:0]    vc [NV];
  logic            vo [NV];
  logic [NI*W-1:0] ve [NV];

  int n_checks = 0;
  int n_errors = 0;

  conjugate_complex_vxc_add_8_delay #(.NI(NI), .W(W), .FRAC(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .first_row_input  (a),
    .constant         (c),
    .second_row_input (b),
    .op               (op),
    .vXc_add_8_output (r),
    .finish_out       (fin)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  function automatic logic [63:0] cx(input logic [31:0] re, input logic [31:0] im);
    return {re, im};
  endfunction

  task automatic chk_vec(input string tag, input logic [NI*W-1:0] obs, input logic [NI*W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i);
    a  = va[i];
    b  = vb[i];
    c  = vc[i];
    op = vo[i];
  endtask

  task automatic drive_zero();
    a  = '0;
    b  = '0;
    c  = '0;
    op = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NV; i++) begin
      va[i] = '0;
      vb[i] = '0;
      ve[i] = '0;
    end
    // 0: C=1, A=2+3j, B=1+1j, add -> 3-2j
    vc[0] = cx(32'h00010000, 32'h00000000);
    va[0][63:0] = cx(32'h00020000, 32'h00030000);
    vb[0][63:0] = cx(32'h00010000, 32'h00010000);
    vo[0] = 1'b0;
    ve[0][63:0] = cx(32'h00030000, 32'hFFFE0000);
    // 1: same operands, subtract -> -1+4j
    vc[1] = vc[0];
    va[1] = va[0];
    vb[1] = vb[0];
    vo[1] = 1'b1;
    ve[1][63:0] = cx(32'hFFFF0000, 32'h00040000);
    // 2: C=j, A[k]=(k+1)+2j, B[k]=k -> R[k]=(k+2)+(k+1)j
    vc[2] = cx(32'h00000000, 32'h00010000);
    vo[2] = 1'b0;
    for (int k = 0; k < NI; k++) begin
      va[2][64*k +: 64] = cx(32'((k + 1) * 65536), 32'h00020000);
      vb[2][64*k +: 64] = cx(32'(k * 65536), 32'h00000000);
      ve[2][64*k +: 64] = cx(32'((k + 2) * 65536), 32'((k + 1) * 65536));
    end
    // 3: wrap, B real 0x7FFFFFFF + 1.0 -> 0x8000FFFF
    vc[3] = cx(32'h00010000, 32'h00000000);
    va[3][63:0] = cx(32'h00010000, 32'h00000000);
    vb[3][63:0] = cx(32'h7FFFFFFF, 32'h00000000);
    vo[3] = 1'b0;
    ve[3][63:0] = cx(32'h8000FFFF, 32'h00000000);
    // 4: C=-0.5, subtract; lane0 A=3 -> 1.5, lane1 A=1ulp -> product floors to -1ulp -> R=+1ulp
    vc[4] = cx(32'hFFFF8000, 32'h00000000);
    va[4][63:0]   = cx(32'h00030000, 32'h00000000);
    va[4][127:64] = cx(32'h00000001, 32'h00000000);
    vo[4] = 1'b1;
    ve[4][63:0]   = cx(32'h00018000, 32'h00000000);
    ve[4][127:64] = cx(32'h00000001, 32'h00000000);

    // Reset held low with busy inputs
    reset = 1'b0;
    a  = {16{32'hDEADBEEF}};
    b  = {16{32'h12345678}};
    c  = 64'hCAFEF00D_01234567;
    op = 1'b1;
    #1;
    chk_vec("rst_out_pre_edge", r, '0);
    chk_bit("rst_fin_pre_edge", fin, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_vec("rst_out_post_edge", r, '0);
    chk_bit("rst_fin_post_edge", fin, 1'b0);

    // Release and stream five vectors back to back
    reset = 1'b1;
    for (int t = 0; t < NV + 2; t++) begin
      if (t < NV) drive(t);
      else drive_zero();
      @(posedge clk);
      @(negedge clk);
      if (t < 2) begin
        chk_vec($sformatf("fill_out_%0d", t), r, '0);
        chk_bit($sformatf("fill_fin_%0d", t), fin, 1'b0);
      end else begin
        chk_vec($sformatf("stream_out_v%0d", t - 2), r, ve[t - 2]);
        chk_bit($sformatf("stream_fin_v%0d", t - 2), fin, 1'b1);
      end
    end

    // Mid-stream reset discards in-flight data immediately
    for (int t = 0; t < 2; t++) begin
      drive(t);
      @(posedge clk);
      @(negedge clk);
    end
    #2;
    reset = 1'b0;
    #1;
    chk_vec("mid_rst_out_now", r, '0);
    chk_bit("mid_rst_fin_now", fin, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_vec("mid_rst_out_held", r, '0);
    chk_bit("mid_rst_fin_held", fin, 1'b0);

    // Release and refill with vector 1
    reset = 1'b1;
    for (int t = 0; t < 3; t++) begin
      if (t == 0) drive(1);
      else drive_zero();
      @(posedge clk);
      @(negedge clk);
      if (t < 2) begin
        chk_vec($sformatf("refill_out_%0d", t), r, '0);
        chk_bit($sformatf("refill_fin_%0d", t), fin, 1'b0);
      end else begin
        chk_vec("refill_out_v1", r, ve[1]);
        chk_bit("refill_fin_v1", fin, 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
